// File: rtl/md5_match_ctrl.sv
// md5_match_ctrl: run controller for a brute-force MD5 search.
// Accepted guesses travel down a delay line that tracks the external hash
// pipeline. Each digest on hash_in is compared with the programmed target slots,
// and every hit is queued in a small FIFO for the host to pop.
// Ports:
//   clk, reset                          clock, async active-high reset
//   tgt_we/tgt_idx/tgt_hash/tgt_clr     target slot programming (IDLE/DONE only)
//   start                               begin a run from IDLE or DONE
//   gen_enable, gen_guess/valid/done    guess generator handshake
//   hash_in                             digest of the guess issued PIPE_LATENCY cycles earlier
//   hit_valid/guess/target, hit_ready   hit FIFO head and pop
//   hit_count, overflow, busy, done     run status
module md5_match_ctrl #(
   parameter int unsigned NUM_TARGETS  = 4,
   parameter int unsigned PIPE_LATENCY = 64,
   parameter int unsigned GUESS_W      = 128,
   parameter int unsigned FIFO_DEPTH   = 8,
   localparam int unsigned IW = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               tgt_we,
   input  logic [IW-1:0]      tgt_idx,
   input  logic [127:0]       tgt_hash,
   input  logic               tgt_clr,
   input  logic               start,
   output logic               gen_enable,
   input  logic [GUESS_W-1:0] gen_guess,
   input  logic               gen_valid,
   input  logic               gen_done,
   input  logic [127:0]       hash_in,
   output logic               hit_valid,
   output logic [GUESS_W-1:0] hit_guess,
   output logic [IW-1:0]      hit_target,
   input  logic               hit_ready,
   output logic [15:0]        hit_count,
   output logic               overflow,
   output logic               busy,
   output logic               done
);

   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW = $clog2(PIPE_LATENCY + 2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic [GUESS_W-1:0] guess;
      logic [IW-1:0]      idx;
   } hit_t;

   state_t                 state_q, state_nx;
   logic                   clear_run, accept, tgt_open, tgt_wr;
   logic [CW-1:0]          drain_cnt_q;

   logic [PIPE_LATENCY-1:0] dl_vld_q;
   logic [GUESS_W-1:0]      dl_guess_q [PIPE_LATENCY];

   logic [127:0]           tgt_hash_q [NUM_TARGETS];
   logic [NUM_TARGETS-1:0] tgt_vld_q;

   logic                   match_any;
   logic [IW-1:0]          match_idx;

   hit_t                   fifo_q [FIFO_DEPTH];
   logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [AW:0]            fcnt_q, fcnt_nx;
   logic                   pop, do_push, fifo_full;

   // Next-state and run-control decode
   always_comb begin
      state_nx  = state_q;
      clear_run = 1'b0;
      accept    = 1'b0;
      tgt_open  = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            tgt_open = 1'b1;
            if (start) begin
               state_nx  = S_RUN;
               clear_run = 1'b1;
            end
         end
         S_RUN: begin
            accept = gen_valid;
            if (gen_done) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            if (drain_cnt_q == CW'(PIPE_LATENCY)) state_nx = S_DONE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // State register and registered state decodes
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         gen_enable <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q    <= state_nx;
         gen_enable <= (state_nx == S_RUN);
         busy       <= (state_nx == S_RUN) || (state_nx == S_DRAIN);
         done       <= (state_nx == S_DONE);
      end
   end

   // Drain cycle counter: counts 0..PIPE_LATENCY while in DRAIN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  drain_cnt_q <= '0;
      else if (state_q != S_DRAIN) drain_cnt_q <= '0;
      else                        drain_cnt_q <= drain_cnt_q + CW'(1);
   end

   // Delay-line valids; the cast drops the oldest bit after shifting in accept
   always_ff @(posedge clk or posedge reset) begin
      if (reset)          dl_vld_q <= '0;
      else if (clear_run) dl_vld_q <= '0;
      else                dl_vld_q <= PIPE_LATENCY'({dl_vld_q, accept});
   end

   // Delay-line guess payload; meaningful only where the matching valid is set
   always_ff @(posedge clk) begin
      dl_guess_q[0] <= gen_guess;
      for (int i = 1; i < int'(PIPE_LATENCY); i++) dl_guess_q[i] <= dl_guess_q[i-1];
   end

   assign tgt_wr = tgt_open && tgt_we && !tgt_clr && (int'(tgt_idx) < int'(NUM_TARGETS));

   // Target valid bits; clear wins over a write
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        tgt_vld_q <= '0;
      else if (tgt_clr) tgt_vld_q <= '0;
      else if (tgt_wr)  tgt_vld_q[tgt_idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (tgt_wr) tgt_hash_q[tgt_idx] <= tgt_hash;
   end

   // Digest compare; descending scan so the lowest matching slot wins
   always_comb begin
      match_any = 1'b0;
      match_idx = '0;
      for (int i = int'(NUM_TARGETS) - 1; i >= 0; i--) begin
         if (dl_vld_q[PIPE_LATENCY-1] && tgt_vld_q[i] && (tgt_hash_q[i] == hash_in)) begin
            match_any = 1'b1;
            match_idx = IW'(i);
         end
      end
   end

   assign fifo_full = (fcnt_q == (AW+1)'(FIFO_DEPTH));
   assign pop       = hit_valid && hit_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push   = match_any && (!fifo_full || pop);

   always_comb begin
      fcnt_nx = fcnt_q;
      if (do_push && !pop)      fcnt_nx = fcnt_q + (AW+1)'(1);
      else if (!do_push && pop) fcnt_nx = fcnt_q - (AW+1)'(1);
   end

   // FIFO pointers, occupancy, hit counter and overflow flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset || clear_run) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fcnt_q    <= '0;
         hit_valid <= 1'b0;
         hit_count <= '0;
         overflow  <= 1'b0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         fcnt_q    <= fcnt_nx;
         hit_valid <= (fcnt_nx != '0);
         if (match_any && (hit_count != 16'hFFFF)) hit_count <= hit_count + 16'd1;
         if (match_any && fifo_full && !pop)       overflow  <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) fifo_q[wr_ptr_q] <= '{guess: dl_guess_q[PIPE_LATENCY-1], idx: match_idx};
   end

   assign hit_guess  = fifo_q[rd_ptr_q].guess;
   assign hit_target = fifo_q[rd_ptr_q].idx;

endmodule

// File: tb/tb_md5_match_ctrl.sv
// Self-checking bench for md5_match_ctrl. The bench plays the hash pipeline
// (digest = guess xor a fixed mask, delayed L cycles) and keeps a reference
// model of the run phases, target slots and hit queue.
module tb_md5_match_ctrl;

   localparam int unsigned NT = 4;
   localparam int unsigned L  = 64;
   localparam int unsigned GW = 128;
   localparam int unsigned FD = 8;
   localparam int unsigned IW = 2;
   localparam logic [127:0] MASK = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

   logic          clk = 1'b0;
   logic          reset;
   logic          tgt_we;
   logic [IW-1:0] tgt_idx;
   logic [127:0]  tgt_hash;
   logic          tgt_clr;
   logic          start;
   logic          gen_enable;
   logic [GW-1:0] gen_guess;
   logic          gen_valid;
   logic          gen_done;
   logic [127:0]  hash_in;
   logic          hit_valid;
   logic [GW-1:0] hit_guess;
   logic [IW-1:0] hit_target;
   logic          hit_ready;
   logic [15:0]   hit_count;
   logic          overflow;
   logic          busy;
   logic          done;

   int total = 0;
   int bad   = 0;

   md5_match_ctrl #(.NUM_TARGETS(NT), .PIPE_LATENCY(L), .GUESS_W(GW), .FIFO_DEPTH(FD)) dut (
      .clk(clk), .reset(reset),
      .tgt_we(tgt_we), .tgt_idx(tgt_idx), .tgt_hash(tgt_hash), .tgt_clr(tgt_clr),
      .start(start), .gen_enable(gen_enable), .gen_guess(gen_guess),
      .gen_valid(gen_valid), .gen_done(gen_done), .hash_in(hash_in),
      .hit_valid(hit_valid), .hit_guess(hit_guess), .hit_target(hit_target),
      .hit_ready(hit_ready), .hit_count(hit_count), .overflow(overflow),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [127:0] dig(input logic [GW-1:0] g);
      return g ^ MASK;
   endfunction

   function automatic logic [GW-1:0] guess_for(input logic [127:0] h);
      return h ^ MASK;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   // Hash pipeline stand-in: hash_in at cycle t+L is the digest of gen_guess at t
   initial begin
      logic [GW-1:0] pq[$];
      hash_in = '0;
      forever begin
         @(posedge clk);
         pq.push_back(gen_guess);
         if (pq.size() > L) void'(pq.pop_front());
         #1;
         hash_in = (pq.size() == L) ? dig(pq[0]) : '0;
      end
   end

   // Reference model and monitor
   typedef struct { logic [GW-1:0] g; int due; } fl_t;
   typedef struct packed { logic [GW-1:0] g; logic [IW-1:0] t; } hit_t;

   fl_t          infl[$];
   hit_t         expq[$];
   int           phase;       // 0 idle, 1 run, 2 drain, 3 done
   int           drain_left;
   int           m_cnt;
   bit           m_ovf;
   logic [127:0] mt_hash [NT];
   bit           mt_vld [NT];
   int           cyc = 0;

   task automatic model_reset();
      infl.delete();
      expq.delete();
      phase = 0;
      drain_left = 0;
      m_cnt = 0;
      m_ovf = 1'b0;
      for (int k = 0; k < int'(NT); k++) mt_vld[k] = 1'b0;
   endtask

   initial begin
      bit  popped;
      int  idx;
      fl_t e;
      model_reset();
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) model_reset();
         chk("gen_enable", gen_enable, phase == 1);
         chk("busy", busy, (phase == 1) || (phase == 2));
         chk("done", done, phase == 3);
         chk("hit_valid", hit_valid, expq.size() != 0);
         chk("hit_count", hit_count, 16'(m_cnt));
         chk("overflow", overflow, m_ovf);
         if (expq.size() != 0) begin
            chk("hit_guess", hit_guess, expq[0].g);
            chk("hit_target", hit_target, expq[0].t);
         end
         if (!reset) begin
            popped = (expq.size() != 0) && hit_ready;
            if (popped) void'(expq.pop_front());
            if (infl.size() != 0 && infl[0].due == cyc) begin
               e = infl.pop_front();
               idx = -1;
               for (int k = int'(NT) - 1; k >= 0; k--)
                  if (mt_vld[k] && mt_hash[k] == dig(e.g)) idx = k;
               if (idx >= 0) begin
                  if (m_cnt < 16'hFFFF) m_cnt++;
                  if (expq.size() == int'(FD)) m_ovf = 1'b1;
                  else expq.push_back('{e.g, IW'(idx)});
               end
            end
            if (phase == 1 && gen_valid) infl.push_back('{gen_guess, cyc + int'(L)});
            if (phase == 0 || phase == 3) begin
               if (tgt_clr) begin
                  for (int k = 0; k < int'(NT); k++) mt_vld[k] = 1'b0;
               end else if (tgt_we && int'(tgt_idx) < int'(NT)) begin
                  mt_vld[tgt_idx]  = 1'b1;
                  mt_hash[tgt_idx] = tgt_hash;
               end
            end
            case (phase)
               0, 3: if (start) begin
                  phase = 1;
                  m_cnt = 0;
                  m_ovf = 1'b0;
                  expq.delete();
                  infl.delete();
               end
               1: if (gen_done) begin
                  phase = 2;
                  drain_left = int'(L) + 1;
               end
               2: begin
                  drain_left--;
                  if (drain_left == 0) phase = 3;
               end
               default: ;
            endcase
         end
      end
   end

   // Stimulus
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_tgt(input int i, input logic [127:0] h);
      tgt_we = 1'b1; tgt_idx = IW'(i); tgt_hash = h;
      step();
      tgt_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send(input logic [GW-1:0] g, input logic v, input logic d);
      gen_guess = g; gen_valid = v; gen_done = d;
      step();
      gen_valid = 1'b0; gen_done = 1'b0;
   endtask

   task automatic drain_fifo();
      hit_ready = 1'b1;
      repeat (FD + 4) step();
      hit_ready = 1'b0;
   endtask

   logic [127:0] h0, h1, h2;
   logic [127:0] rh [NT];

   initial begin
      h0 = 128'h98500190b04fd23c7d3f96d6727fe128;
      h1 = rnd128();
      h2 = rnd128();
      reset = 1'b1; tgt_we = 1'b0; tgt_idx = '0; tgt_hash = '0; tgt_clr = 1'b0;
      start = 1'b0; gen_guess = '0; gen_valid = 1'b0; gen_done = 1'b0; hit_ready = 1'b0;
      repeat (3) step();
      reset = 1'b0;
      step();

      // Single match on slot 0; a valid guess in IDLE must be ignored
      write_tgt(0, h0);
      send(guess_for(h0), 1'b1, 1'b0);
      pulse_start();
      repeat (3) send(rnd128(), 1'b1, 1'b0);
      send(guess_for(h0), 1'b1, 1'b0);
      send(rnd128(), 1'b1, 1'b0);
      send(rnd128(), 1'b0, 1'b1);
      repeat (L + 4) step();
      drain_fifo();

      // Duplicate digest in slots 1 and 3: one entry reporting slot 1
      write_tgt(1, h1);
      write_tgt(3, h1);
      pulse_start();
      send(guess_for(h1), 1'b1, 1'b0);
      send(rnd128(), 1'b0, 1'b1);
      repeat (L + 4) step();
      drain_fifo();

      // Overflow: FD+2 matches with no pops
      pulse_start();
      for (int i = 0; i < int'(FD) + 2; i++)
         send(guess_for((i % 2 == 0) ? h0 : h1), 1'b1, 1'b0);
      send(rnd128(), 1'b0, 1'b1);
      repeat (L + 4) step();
      drain_fifo();

      // Randomised run; slot 2 holds a stale, invalidated hash
      for (int k = 0; k < int'(NT); k++) begin
         rh[k] = rnd128();
         write_tgt(k, rh[k]);
      end
      tgt_clr = 1'b1;
      step();
      tgt_clr = 1'b0;
      write_tgt(0, rh[0]);
      write_tgt(1, rh[1]);
      write_tgt(3, rh[3]);
      pulse_start();
      for (int i = 0; i < 300; i++) begin
         hit_ready = 1'($urandom_range(0, 1));
         start = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 3) == 0) gen_guess = rnd128();
         else gen_guess = guess_for(rh[$urandom_range(0, NT - 1)]);
         gen_valid = ($urandom_range(0, 9) < 7);
         step();
      end
      start = 1'b0;
      // Last guess arrives together with gen_done and must still be compared
      send(guess_for(rh[0]), 1'b1, 1'b1);
      for (int i = 0; i < int'(L) + 4; i++) begin
         hit_ready = 1'($urandom_range(0, 1));
         step();
      end
      drain_fifo();

      // Reset mid-run with three guesses in flight
      pulse_start();
      repeat (3) send(guess_for(rh[1]), 1'b1, 1'b0);
      repeat (5) step();
      reset = 1'b1;
      repeat (2) step();
      reset = 1'b0;
      repeat (L + 6) step();

      // Target write during RUN is ignored; slot 0 keeps its hash
      write_tgt(0, h0);
      pulse_start();
      write_tgt(1, h2);
      send(guess_for(h2), 1'b1, 1'b0);
      send(guess_for(h0), 1'b1, 1'b0);
      send(rnd128(), 1'b0, 1'b1);
      repeat (L + 4) step();
      drain_fifo();

      // tgt_clr with tgt_we in IDLE leaves every slot invalid
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
      write_tgt(0, h0);
      write_tgt(2, h2);
      tgt_clr = 1'b1; tgt_we = 1'b1; tgt_idx = IW'(3); tgt_hash = h1;
      step();
      tgt_clr = 1'b0; tgt_we = 1'b0;
      pulse_start();
      send(guess_for(h0), 1'b1, 1'b0);
      send(guess_for(h2), 1'b1, 1'b0);
      send(guess_for(h1), 1'b1, 1'b1);
      repeat (L + 4) step();
      drain_fifo();

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/md5_match_ctrl.md
MD5_MATCH_CTRL -- requirements
Module: md5_match_ctrl

Interface
REQ-001 SHALL have parameter NUM_TARGETS, default 4, meaning the number of programmable 128-bit target hashes (1..16).
REQ-002 SHALL have parameter PIPE_LATENCY, default 64, meaning the cycles from a guess entering the hash pipeline to its digest appearing on hash_in (at least 1).
REQ-003 SHALL have parameter GUESS_W, default 128, meaning the guess width.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8, meaning the hit FIFO entries (power of 2, at least 2).
REQ-005 SHALL have these ports (IW = max(1, clog2(NUM_TARGETS))):
 clk  in  1  sole clock, rising edge.
 reset  in  1  asynchronous, active-high.
 tgt_we  in  1  target write strobe.
 tgt_idx  in  IW  target slot index.
 tgt_hash  in  128  target digest {A,B,C,D}, A in [127:96].
 tgt_clr  in  1  invalidates all target slots.
 start  in  1  begins a run.
 gen_enable  out  1  generator may advance, high only in RUN.
 gen_guess  in  GUESS_W  current guess.
 gen_valid  in  1  gen_guess valid this cycle.
 gen_done  in  1  generator exhausted keyspace.
 hash_in  in  128  pipeline digest, {A,B,C,D} packing.
 hit_valid  out  1  FIFO non-empty.
 hit_guess  out  GUESS_W  guess at FIFO head.
 hit_target  out  IW  matched slot at FIFO head.
 hit_ready  in  1  pop FIFO head.
 hit_count  out  16  hits found this run, saturating.
 overflow  out  1  sticky, a hit was dropped.
 busy  out  1  state is RUN or DRAIN.
 done  out  1  state is DONE.

Function
REQ-006 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
REQ-007 IDLE or DONE with start=1 SHALL go to RUN, clearing hit_count, overflow, the delay-line valids and the FIFO; start SHALL be ignored in RUN and DRAIN.
REQ-008 In RUN, gen_done=1 SHALL go to DRAIN next cycle; a guess with gen_valid=1 in that same cycle SHALL be accepted.
REQ-009 A guess SHALL be accepted only when state=RUN and gen_valid=1; gen_valid in any other state SHALL be ignored.
REQ-010 An accepted guess at cycle t, with its valid bit, SHALL be delayed PIPE_LATENCY cycles so that it aligns with hash_in at cycle t+PIPE_LATENCY.
REQ-011 Comparison SHALL occur only when the delayed valid bit is set; a target slot matches when its valid bit is set and its hash equals hash_in on all 128 bits.
REQ-012 When several slots match the same digest, the lowest index SHALL be reported with one FIFO entry and hit_count SHALL increase by 1.
REQ-013 A match at cycle c SHALL write {guess, index} into the FIFO, visible as hit_valid=1 at c+1 when the FIFO was empty.
REQ-014 hit_count SHALL increment by 1 per match, including dropped matches, and saturate at 16'hFFFF.
REQ-015 A pop SHALL occur when hit_valid and hit_ready are both 1; hit_ready with an empty FIFO SHALL have no effect.
REQ-016 On a push with the FIFO full and no pop, the entry SHALL be dropped and overflow set; a push and pop in the same cycle while full SHALL both succeed.
REQ-017 FIFO order SHALL be first-in first-out; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-018 DRAIN SHALL last exactly PIPE_LATENCY+1 cycles, then go to DONE; gen_enable SHALL be 0 during the drain.
REQ-019 DONE SHALL hold hit_count, overflow and the FIFO contents, and popping SHALL remain allowed.
REQ-020 A target write SHALL load the slot and set its valid bit at the next edge only in IDLE or DONE; writes with tgt_idx >= NUM_TARGETS or in RUN/DRAIN SHALL be ignored.
REQ-021 tgt_clr SHALL clear all valid bits, and SHALL take priority over a simultaneous tgt_we.
REQ-022 gen_enable, busy and done SHALL be registered state decodes.

Reset
REQ-023 reset=1 SHALL immediately force IDLE, empty FIFO, hit_valid=0, hit_count=0, overflow=0, busy=0, done=0, gen_enable=0, all delay-line and target valid bits 0.
REQ-024 Assertion of reset in RUN or DRAIN SHALL abort the run, discard in-flight guesses and produce no further hits.

Verification
REQ-025 Load slot 0=98500190b04fd23c7d3f96d6727fe128, start, present a guess whose digest matches at t=5 -> hit_valid at cycle 5+PIPE_LATENCY+1, hit_target=0, hit_count=1.
REQ-026 Load slots 1 and 3 with the same digest and match once -> one FIFO entry, hit_target=1, hit_count=1.
REQ-027 With hit_ready=0, cause FIFO_DEPTH+2 matches -> FIFO holds the first 8, overflow=1, hit_count=10; popping yields them in order.
REQ-028 gen_done together with gen_valid at cycle t -> that guess is still compared, and done rises at cycle t+PIPE_LATENCY+2.
REQ-029 Assert reset mid-RUN with 3 guesses in flight -> all outputs take their reset values and no hit_valid appears afterwards.
REQ-030 Issue tgt_we during RUN, then tgt_clr and tgt_we together in IDLE -> target memory is unchanged in the first case and all slots are invalid in the second.
